// File: rtl/pipe_mux_tree_pkg.sv
// Shared sizing helpers for the pipelined mux tree.
package pipe_mux_tree_pkg;

    localparam int COUNT_W = 16;

    // Number of register stages: one per radix-4 level, the last may be radix-2.
    function automatic int clog4_stages(input int sel_w);
        return (sel_w + 1) / 2;
    endfunction

    // Words left after stage s has resolved its select bits; s = -1 gives the input width.
    function automatic int stage_words(input int sel_w, input int s);
        int consumed;
        consumed = 2 * (s + 1);
        if (consumed > sel_w) consumed = sel_w;
        if (consumed < 0) consumed = 0;
        return 1 << (sel_w - consumed);
    endfunction

endpackage

// File: rtl/pmux_stage.sv
// One tree level: radix-4 or radix-2 word select followed by a valid/ready
// register slice. The full select and tag ride along unchanged.
module pmux_stage
    import pipe_mux_tree_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IN_WORDS = 4,
    parameter int RADIX    = 4,
    parameter int SEL_W    = 2,
    parameter int SEL_LSB  = 0,
    parameter int TAG_W    = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 up_valid_i,
    output logic                                 up_ready_o,
    input  logic [IN_WORDS*DATA_W-1:0]           up_data_i,
    input  logic [SEL_W-1:0]                     up_sel_i,
    input  logic [TAG_W-1:0]                     up_tag_i,
    output logic                                 dn_valid_o,
    input  logic                                 dn_ready_i,
    output logic [(IN_WORDS/RADIX)*DATA_W-1:0]   dn_data_o,
    output logic [SEL_W-1:0]                     dn_sel_o,
    output logic [TAG_W-1:0]                     dn_tag_o
);

    localparam int OUT_WORDS = IN_WORDS / RADIX;
    localparam int RW        = (RADIX == 4) ? 2 : 1;

    logic                          valid_q;
    logic [OUT_WORDS*DATA_W-1:0]   data_q;
    logic [OUT_WORDS*DATA_W-1:0]   data_d;
    logic [SEL_W-1:0]              sel_q;
    logic [TAG_W-1:0]              tag_q;
    logic [RW-1:0]                 sub;

    // Lower select bits are resolved first, so group j holds words j*RADIX .. j*RADIX+RADIX-1.
    assign sub        = up_sel_i[SEL_LSB +: RW];
    assign up_ready_o = !valid_q || dn_ready_i;

    // Pick one word out of every group of RADIX inputs.
    always_comb begin
        data_d = '0;
        for (int j = 0; j < OUT_WORDS; j++) begin
            data_d[j*DATA_W +: DATA_W] = up_data_i[(j*RADIX + int'(sub))*DATA_W +: DATA_W];
        end
    end

    // Register slice: load whenever ready; an invalid upstream becomes a bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            tag_q   <= '0;
        end else if (up_ready_o) begin
            valid_q <= up_valid_i;
            if (up_valid_i) begin
                data_q <= data_d;
                sel_q  <= up_sel_i;
                tag_q  <= up_tag_i;
            end
        end
    end

    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;
    assign dn_sel_o   = sel_q;
    assign dn_tag_o   = tag_q;

endmodule

// File: rtl/pipe_mux_tree.sv
// Pipelined N:1 word mux built from chained pmux_stage levels, plus an
// output-transfer counter.
module pipe_mux_tree
    import pipe_mux_tree_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5,
    parameter int TAG_W  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [SEL_W-1:0]             sel_i,
    input  logic [(1<<SEL_W)*DATA_W-1:0] data_i,
    input  logic [TAG_W-1:0]             tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_W-1:0]            data_o,
    output logic [SEL_W-1:0]             sel_o,
    output logic [TAG_W-1:0]             tag_o,
    output logic [COUNT_W-1:0]           count_o
);

    localparam int L = clog4_stages(SEL_W);

    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] cnt_d;

    genvar s;
    generate
        for (s = 0; s < L; s++) begin : g_st
            localparam int IW = stage_words(SEL_W, s - 1);
            localparam int OW = stage_words(SEL_W, s);

            logic                 up_v;
            logic                 up_r;
            logic [IW*DATA_W-1:0] up_d;
            logic [SEL_W-1:0]     up_s;
            logic [TAG_W-1:0]     up_t;
            logic                 dn_v;
            logic                 dn_r;
            logic [OW*DATA_W-1:0] dn_d;
            logic [SEL_W-1:0]     dn_s;
            logic [TAG_W-1:0]     dn_t;

            if (s == 0) begin : g_first
                assign up_v = in_valid_i;
                assign up_d = data_i;
                assign up_s = sel_i;
                assign up_t = tag_i;
            end else begin : g_chain
                assign up_v = g_st[s-1].dn_v;
                assign up_d = g_st[s-1].dn_d;
                assign up_s = g_st[s-1].dn_s;
                assign up_t = g_st[s-1].dn_t;
            end

            if (s == L - 1) begin : g_last
                assign dn_r = out_ready_i;
            end else begin : g_inner
                assign dn_r = g_st[s+1].up_r;
            end

            pmux_stage #(
                .DATA_W   (DATA_W),
                .IN_WORDS (IW),
                .RADIX    (IW / OW),
                .SEL_W    (SEL_W),
                .SEL_LSB  (2 * s),
                .TAG_W    (TAG_W)
            ) u_stage (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .up_valid_i (up_v),
                .up_ready_o (up_r),
                .up_data_i  (up_d),
                .up_sel_i   (up_s),
                .up_tag_i   (up_t),
                .dn_valid_o (dn_v),
                .dn_ready_i (dn_r),
                .dn_data_o  (dn_d),
                .dn_sel_o   (dn_s),
                .dn_tag_o   (dn_t)
            );
        end
    endgenerate

    assign in_ready_o  = g_st[0].up_r;
    assign out_valid_o = g_st[L-1].dn_v;
    assign data_o      = g_st[L-1].dn_d;
    assign sel_o       = g_st[L-1].dn_s;
    assign tag_o       = g_st[L-1].dn_t;

    // Next count: bump on every accepted output beat, wrapping naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_o && out_ready_i) cnt_d = cnt_q + 1'b1;
    end

    // Transfer counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule
